octave_tone_gen: RTL and testbench

//  Stage directly downstream of the 12-key note mux. It takes the note mux's half-period reload

---
 rtl/octave_tone_gen_pkg.sv | 43 ++++
 rtl/octave_tone_gen_octave_ctrl.sv | 54 +++++
 rtl/octave_tone_gen.sv | 115 +++++++++++
 tb/tb_octave_tone_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/octave_tone_gen_pkg.sv
// Shared constants, FSM encoding and scaling helpers for the octave tone generator.
// Pure combinational helpers, no latency of their own.
// No flow control; values are consumed by the top and the octave controller.
package octave_tone_gen_pkg;

  localparam int RELOAD_W   = 20;
  localparam int FREQ_W     = 23;
  localparam int BASE_SHIFT = 2;

  localparam logic [2:0] OCT_MIN = 3'd3;
  localparam logic [2:0] OCT_MAX = 3'd7;
  localparam logic [2:0] OCT_RST = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Half-period reload at the given octave; the mux value is defined at OCT_RST.
  // The top octave runs above the mux's base pitch, hence the single right shift.
  function automatic logic [RELOAD_W-1:0] scale_half(input logic [RELOAD_W-1:0] reload,
                                                     input logic [2:0]          oct);
    int sh;
    sh = BASE_SHIFT + int'(OCT_RST) - int'(oct);
    if (sh >= 0) begin
      return reload << sh;
    end
    return reload >> 1;
  endfunction

  // Displayed frequency x1000 at the given octave; octave 3 halves the base value.
  function automatic logic [FREQ_W-1:0] scale_freq(input logic [RELOAD_W-1:0] freq,
                                                   input logic [2:0]          oct);
    logic [FREQ_W-1:0] fw;
    fw = {{(FREQ_W-RELOAD_W){1'b0}}, freq};
    if (oct >= OCT_RST) begin
      return fw << (oct - OCT_RST);
    end
    return fw >> 1;
  endfunction

endpackage

// File: rtl/octave_tone_gen_octave_ctrl.sv
// Octave selector: rising-edge detect on up/down keys, saturating octave register.
// Latency: octave and check_octave_seven update the cycle after a key edge.
// No backpressure; key levels are sampled every cycle.
module octave_ctrl
  import octave_tone_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oct_up,
  input  logic       oct_down,
  output logic [2:0] octave,
  output logic       check_octave_seven
);

  logic       up_prev_q, up_prev_d;
  logic       down_prev_q, down_prev_d;
  logic [2:0] octave_q, octave_d;
  logic       chk7_q, chk7_d;
  logic       up_edge, down_edge;

  // Edge detection and saturating step; simultaneous up and down edges cancel.
  always_comb begin
    up_prev_d   = oct_up;
    down_prev_d = oct_down;
    up_edge     = oct_up & ~up_prev_q;
    down_edge   = oct_down & ~down_prev_q;
    octave_d    = octave_q;
    if (up_edge && !down_edge && (octave_q != OCT_MAX)) begin
      octave_d = octave_q + 3'd1;
    end else if (down_edge && !up_edge && (octave_q != OCT_MIN)) begin
      octave_d = octave_q - 3'd1;
    end
    chk7_d = (octave_d == OCT_MAX);
  end

  // Key history, octave and top-octave flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      octave_q    <= OCT_RST;
      chk7_q      <= 1'b0;
    end else begin
      up_prev_q   <= up_prev_d;
      down_prev_q <= down_prev_d;
      octave_q    <= octave_d;
      chk7_q      <= chk7_d;
    end
  end

  assign octave             = octave_q;
  assign check_octave_seven = chk7_q;

endmodule

// File: rtl/octave_tone_gen.sv
// Octave-shifted square-wave tone generator with glitch-free period-boundary updates.
// Latency: tone starts high one cycle after a key appears; freq_milli is registered (1 cycle).
// No backpressure; pitch/octave changes wait for the next full-period boundary.
module octave_tone_gen
  import octave_tone_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RELOAD_W-1:0] note_reload,
  input  logic [RELOAD_W-1:0] note_freq,
  input  logic                oct_up,
  input  logic                oct_down,
  output logic                tone_out,
  output logic                busy,
  output logic [2:0]          octave,
  output logic                check_octave_seven,
  output logic [FREQ_W-1:0]   freq_milli
);

  localparam logic [RELOAD_W-1:0] ONE = {{(RELOAD_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [RELOAD_W-1:0] cnt_q, cnt_d;
  logic [RELOAD_W-1:0] act_half_q, act_half_d;
  logic                tone_q, tone_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [RELOAD_W-1:0] half;
  logic                key_on;
  logic                low_end;

  octave_ctrl u_octave_ctrl (
    .clk                (clk),
    .rst_n              (rst_n),
    .oct_up             (oct_up),
    .oct_down           (oct_down),
    .octave             (octave),
    .check_octave_seven (check_octave_seven)
  );

  // Scaling, displayed frequency and tone FSM; a new half value is only taken
  // when a period starts, so a running half-period is never shortened or split.
  always_comb begin
    half       = scale_half(note_reload, octave);
    key_on     = (note_reload != '0);
    freq_d     = key_on ? scale_freq(note_freq, octave) : '0;
    low_end    = (cnt_q == '0) && !tone_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_half_d = act_half_q;
    tone_d     = tone_q;
    unique case (state_q)
      IDLE: begin
        tone_d = 1'b0;
        if (key_on) begin
          state_d    = PLAY;
          act_half_d = half;
          cnt_d      = half - ONE;
          tone_d     = 1'b1;
        end
      end
      PLAY, RELEASE: begin
        if (low_end) begin
          // Full-period boundary: start the next period or fall silent.
          if (key_on) begin
            state_d    = PLAY;
            act_half_d = half;
            cnt_d      = half - ONE;
            tone_d     = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            tone_d  = 1'b0;
          end
        end else begin
          if (cnt_q == '0) begin
            tone_d = 1'b0;
            cnt_d  = act_half_q - ONE;
          end else begin
            cnt_d = cnt_q - ONE;
          end
          if ((state_q == PLAY) && !key_on) begin
            state_d = RELEASE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  // FSM, counter, tone and frequency registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_half_q <= '0;
      tone_q     <= 1'b0;
      freq_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_half_q <= act_half_d;
      tone_q     <= tone_d;
      freq_q     <= freq_d;
    end
  end

  assign tone_out   = tone_q;
  assign busy       = (state_q != IDLE);
  assign freq_milli = freq_q;

endmodule

// File: tb/tb_octave_tone_gen.sv
// Scoreboard bench for octave_tone_gen: expected half-periods queued by stimulus,
// popped and compared by a monitor at each tone transition; static outputs checked directly.
// Every wait is bounded; a timeout counts as a failed comparison.
module tb_octave_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] note_reload;
  logic [19:0] note_freq;
  logic        oct_up;
  logic        oct_down;
  logic        tone_out;
  logic        busy;
  logic [2:0]  octave;
  logic        check_octave_seven;
  logic [22:0] freq_milli;

  typedef struct {
    logic lvl;
    int   len;
  } half_t;

  half_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  bit    synced  = 1'b0;
  logic  prev_tone = 1'b0;
  int    run = 0;

  octave_tone_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .note_reload        (note_reload),
    .note_freq          (note_freq),
    .oct_up             (oct_up),
    .oct_down           (oct_down),
    .tone_out           (tone_out),
    .busy               (busy),
    .octave             (octave),
    .check_octave_seven (check_octave_seven),
    .freq_milli         (freq_milli)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic lvl, input int len);
    half_t e;
    e.lvl = lvl;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Wait until the scoreboard has drained to 'left' entries, within a cycle budget.
  task automatic wait_q(input int left, input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), left);
  endtask

  task automatic resync();
    mon_en = 1'b0;
    tick(2);
    mon_en = 1'b1;
  endtask

  // Monitor: measure each completed tone run and compare it with the queue head.
  always @(negedge clk) begin
    half_t e;
    if (tone_out !== prev_tone) begin
      if (mon_en && synced && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("half_level", prev_tone, e.lvl);
        check("half_len", run, e.len);
      end
      synced = mon_en;
      run    = 1;
    end else begin
      run++;
    end
    if (!mon_en) synced = 1'b0;
    prev_tone = tone_out;
  end

  initial begin
    int lows;
    int guard;
    rst_n       = 1'b0;
    note_reload = '0;
    note_freq   = '0;
    oct_up      = 1'b0;
    oct_down    = 1'b0;

    // Reset state
    #12;
    check("rst_tone", tone_out, 0);
    check("rst_busy", busy, 0);
    check("rst_octave", octave, 4);
    check("rst_chk7", check_octave_seven, 0);
    check("rst_freq", freq_milli, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("idle_tone", tone_out, 0);
    check("idle_busy", busy, 0);

    // Steady note at octave 4: reload 25 -> 100-cycle halves
    mon_en = 1'b1;
    push(1'b1, 100);
    push(1'b0, 100);
    push(1'b1, 100);
    note_reload = 20'd25;
    note_freq   = 20'd440000;
    tick(2);
    check("play_freq", freq_milli, 440000);
    check("play_busy", busy, 1);
    check("play_tone", tone_out, 1);
    wait_q(0, 1000, "play_halves");

    // Pitch change mid-high: current period finishes, then 80-cycle halves
    push(1'b0, 100);
    push(1'b1, 100);
    push(1'b0, 100);
    push(1'b1, 80);
    push(1'b0, 80);
    wait_q(4, 300, "chg_sync");
    tick(10);
    note_reload = 20'd20;
    wait_q(0, 1000, "chg_halves");

    // Release mid-high: period completes, idle the cycle after the low half
    push(1'b1, 80);
    tick(10);
    note_reload = '0;
    guard = 0;
    while (tone_out !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    lows = 0;
    while (busy === 1'b1 && guard < 400) begin
      lows++;
      @(negedge clk);
      guard++;
    end
    check("rel_low_len", lows, 80);
    check("rel_tone", tone_out, 0);
    check("rel_busy", busy, 0);
    tick(2);
    check("rel_freq", freq_milli, 0);

    // Simultaneous up/down edges leave the octave alone
    oct_up   = 1'b1;
    oct_down = 1'b1;
    tick(1);
    check("both_keys", octave, 4);
    oct_up   = 1'b0;
    oct_down = 1'b0;
    tick(1);
    check("both_keys_rel", octave, 4);

    // Octave up to 7, then saturate
    for (int i = 5; i <= 7; i++) begin
      oct_up = 1'b1;
      tick(1);
      check("oct_up", octave, i);
      oct_up = 1'b0;
      tick(1);
    end
    check("chk7_on", check_octave_seven, 1);
    oct_up = 1'b1;
    tick(1);
    check("oct_sat_hi", octave, 7);
    oct_up = 1'b0;
    tick(1);
    check("chk7_hold", check_octave_seven, 1);

    // A4 at octave 7: 28409 >> 1 = 14204-cycle halves, 440000 << 3
    resync();
    push(1'b1, 14204);
    note_freq   = 20'd440000;
    note_reload = 20'd28409;
    tick(2);
    check("oct7_freq", freq_milli, 3520000);
    wait_q(0, 15000, "oct7_high");
    guard = 0;
    while (tone_out !== 1'b1 && guard < 15000) begin
      tick(1);
      guard++;
    end
    check("oct7_rise", tone_out, 1);
    tick(50);

    // Asynchronous reset mid-note
    mon_en      = 1'b0;
    note_reload = 20'd25;
    rst_n       = 1'b0;
    #1;
    check("arst_tone", tone_out, 0);
    check("arst_octave", octave, 4);
    check("arst_chk7", check_octave_seven, 0);
    check("arst_busy", busy, 0);
    check("arst_freq", freq_milli, 0);
    tick(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push(1'b1, 100);
    push(1'b0, 100);
    tick(1);
    check("restart_tone", tone_out, 1);
    wait_q(0, 500, "restart_halves");

    // Down to octave 3: frequency halves, further down saturates
    oct_down = 1'b1;
    tick(1);
    check("oct_down", octave, 3);
    oct_down = 1'b0;
    tick(1);
    check("oct3_freq", freq_milli, 220000);
    oct_down = 1'b1;
    tick(1);
    check("oct_sat_lo", octave, 3);
    oct_down = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
